wtb_loader: RTL and testbench

- Sequences a wavetable load: on each wtb_load pulse it copies one waveform, selected by (wtb_num, wfm_num), from external sample storage into the oscillator wave RAM.
- The wave RAM is double-buffered. The block fills the inactive bank, then swaps play_bank so playback never reads a half-written waveform.
- Sits between the CC decoder (wtb_load/wtb_num/wfm_num) and the storage read port / oscillator wave RAM write port.

---
 rtl/wtb_loader_pkg.sv | 24 ++
 rtl/wtb_loader.sv | 162 ++++++++++++++++
 tb/tb_wtb_loader.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wtb_loader_pkg.sv
// rtl/wtb_loader_pkg.sv - shared state encoding and address field layout for wtb_loader
package wtb_loader_pkg;

  // Loader FSM states; encodings are fixed so debug probes read the same everywhere.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Wavetable and waveform numbers are both 7 bits wide.
  localparam int NUM_W = 7;

  // Storage address is {wtb, wfm, idx}; idx occupies the low ADDR_W bits.
  function automatic int wfm_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int wtb_lsb(input int addr_w);
    return addr_w + NUM_W;
  endfunction

endpackage

// File: rtl/wtb_loader.sv
// rtl/wtb_loader.sv - double-buffered wavetable loader from sample storage into wave RAM
module wtb_loader
  import wtb_loader_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wtb_load,
  input  logic [NUM_W-1:0]      wtb_num,
  input  logic [NUM_W-1:0]      wfm_num,
  output logic                  src_req,
  output logic [14+ADDR_W-1:0]  src_addr,
  input  logic                  src_ack,
  input  logic [SAMPLE_W-1:0]   src_data,
  output logic                  wr_en,
  output logic                  wr_bank,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [SAMPLE_W-1:0]   wr_data,
  output logic                  play_bank,
  output logic                  busy,
  output logic                  done
);

  localparam int WFM_LSB = wfm_lsb(ADDR_W);
  localparam int WTB_LSB = wtb_lsb(ADDR_W);
  localparam logic [ADDR_W-1:0] IDX_LAST = '1;

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    idx;
  logic [NUM_W-1:0]     cur_wtb, cur_wfm;
  logic [NUM_W-1:0]     pend_wtb, pend_wfm;
  logic                 pending;
  logic [SAMPLE_W-1:0]  sample;

  // Control strobes from the FSM to the datapath registers.
  logic start_in;
  logic start_pend;
  logic capture;
  logic idx_inc;
  logic bank_flip;
  logic set_pend;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and output decode; a request arriving in DONE beats an older pending one.
  always_comb begin
    state_nxt  = state;
    start_in   = 1'b0;
    start_pend = 1'b0;
    capture    = 1'b0;
    idx_inc    = 1'b0;
    bank_flip  = 1'b0;
    set_pend   = 1'b0;
    src_req    = 1'b0;
    wr_en      = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (wtb_load) begin
          start_in  = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        src_req  = 1'b1;
        set_pend = wtb_load;
        if (src_ack) begin
          capture   = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        wr_en    = 1'b1;
        set_pend = wtb_load;
        if (idx == IDX_LAST) begin
          bank_flip = 1'b1;
          state_nxt = DONE;
        end else begin
          idx_inc   = 1'b1;
          state_nxt = REQ;
        end
      end
      DONE: begin
        done = 1'b1;
        if (wtb_load) begin
          start_in  = 1'b1;
          state_nxt = REQ;
        end else if (pending) begin
          start_pend = 1'b1;
          state_nxt  = REQ;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Current selection, sample index and captured sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_wtb <= '0;
      cur_wfm <= '0;
      idx     <= '0;
      sample  <= '0;
    end else begin
      if (start_in) begin
        cur_wtb <= wtb_num;
        cur_wfm <= wfm_num;
        idx     <= '0;
      end else if (start_pend) begin
        cur_wtb <= pend_wtb;
        cur_wfm <= pend_wfm;
        idx     <= '0;
      end else if (idx_inc) begin
        idx <= idx + 1'b1;
      end
      if (capture) sample <= src_data;
    end
  end

  // Single-entry pending latch; a newer request overwrites an older one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= 1'b0;
      pend_wtb <= '0;
      pend_wfm <= '0;
    end else if (set_pend) begin
      pending  <= 1'b1;
      pend_wtb <= wtb_num;
      pend_wfm <= wfm_num;
    end else if (start_in || start_pend) begin
      pending <= 1'b0;
    end
  end

  // Playback bank flips on the edge the last sample is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            play_bank <= 1'b0;
    else if (bank_flip) play_bank <= ~play_bank;
  end

  // Storage address assembled from the field offsets.
  always_comb begin
    src_addr                           = '0;
    src_addr[ADDR_W-1:0]               = idx;
    src_addr[WFM_LSB +: NUM_W]         = cur_wfm;
    src_addr[WTB_LSB +: NUM_W]         = cur_wtb;
  end

  assign wr_bank = ~play_bank;
  assign wr_addr = idx;
  assign wr_data = sample;

endmodule

// File: tb/tb_wtb_loader.sv
// tb/tb_wtb_loader.sv - directed self-checking bench for wtb_loader
module tb_wtb_loader;

  localparam int SAMPLE_W = 8;
  localparam int ADDR_W   = 3;
  localparam int N        = 8;
  localparam int AW       = 14 + ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              wtb_load;
  logic [6:0]        wtb_num, wfm_num;
  logic              src_req;
  logic [AW-1:0]     src_addr;
  logic              src_ack;
  logic [7:0]        src_data;
  logic              wr_en, wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              play_bank, busy, done;

  wtb_loader #(.SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .wtb_load(wtb_load), .wtb_num(wtb_num), .wfm_num(wfm_num),
    .src_req(src_req), .src_addr(src_addr), .src_ack(src_ack), .src_data(src_data),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .play_bank(play_bank), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int                wr_cnt, req_cnt, done_cnt;
  logic [ADDR_W-1:0] wr_addr_log [0:31];
  logic [7:0]        wr_data_log [0:31];
  logic              wr_bank_log [0:31];
  logic [AW-1:0]     req_log     [0:31];
  int                done_cyc    [0:3];
  logic              pb_done     [0:3];
  int                unstable, noack, overlap, busy_gap;

  int         inj_cyc [0:2];
  logic [6:0] inj_wtb [0:2];
  logic [6:0] inj_wfm [0:2];
  bit         load_on_done;
  logic [6:0] lod_wtb, lod_wfm;

  function automatic logic [AW-1:0] exp_addr(input logic [6:0] wtb, input logic [6:0] wfm,
                                             input logic [ADDR_W-1:0] i);
    return {wtb, wfm, i};
  endfunction

  function automatic logic [7:0] exp_data(input logic [6:0] wtb, input logic [6:0] wfm,
                                          input logic [ADDR_W-1:0] i);
    logic [AW-1:0] a;
    a = {wtb, wfm, i};
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic clear_inject();
    for (int k = 0; k < 3; k++) inj_cyc[k] = -1;
    load_on_done = 1'b0;
  endtask

  task automatic pulse_load(input logic [6:0] wtb, input logic [6:0] wfm);
    @(negedge clk);
    wtb_load = 1'b1;
    wtb_num  = wtb;
    wfm_num  = wfm;
  endtask

  // Storage model and write monitor; runs until n_done done pulses or max_cyc cycles.
  task automatic serve(input bit rnd, input int n_done, input int max_cyc);
    int            wait_left;
    bit            have_req, acked;
    logic [AW-1:0] held;
    wait_left = 0; have_req = 0; acked = 0; held = '0;
    wr_cnt = 0; req_cnt = 0; done_cnt = 0;
    unstable = 0; noack = 0; overlap = 0; busy_gap = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      wtb_load = 1'b0;
      src_ack  = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (inj_cyc[k] == c) begin
          wtb_load = 1'b1; wtb_num = inj_wtb[k]; wfm_num = inj_wfm[k];
        end
      end
      if (wr_en) begin
        if (!acked) noack++;
        acked = 0;
        if (src_req) overlap++;
        if (wr_cnt < 32) begin
          wr_addr_log[wr_cnt] = wr_addr;
          wr_data_log[wr_cnt] = wr_data;
          wr_bank_log[wr_cnt] = wr_bank;
        end
        wr_cnt++;
      end
      if (!busy) busy_gap++;
      if (done) begin
        pb_done[done_cnt]  = play_bank;
        done_cyc[done_cnt] = c;
        done_cnt++;
        if (done_cnt == n_done) break;
        if (load_on_done) begin
          wtb_load = 1'b1; wtb_num = lod_wtb; wfm_num = lod_wfm;
        end
      end
      if (src_req) begin
        if (!have_req) begin
          have_req = 1;
          held     = src_addr;
          if (req_cnt < 32) req_log[req_cnt] = src_addr;
          req_cnt++;
          wait_left = rnd ? int'($urandom_range(0, 4)) : 0;
        end else if (src_addr !== held) begin
          unstable++;
        end
        if (wait_left == 0) begin
          src_ack  = 1'b1;
          src_data = held[7:0] ^ 8'hA5;
          have_req = 0;
          acked    = 1;
        end else begin
          wait_left--;
        end
      end
    end
    wtb_load = 1'b0;
    src_ack  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({src_req, src_addr, wr_en, wr_addr, wr_data, play_bank, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b addr=%h wen=%b waddr=%0d wdata=%h pb=%b busy=%b done=%b, expected all 0",
               src_req, src_addr, wr_en, wr_addr, wr_data, play_bank, busy, done);
    end
    checks++;
    if (wr_bank !== 1'b1) begin
      errors++; $display("FAIL reset_wr_bank: got %b expected 1", wr_bank);
    end
  endtask

  task automatic test_zero_wait();
    int bad;
    checks++;
    if (play_bank !== 1'b0) begin
      errors++; $display("FAIL zw_pb_before: got %b expected 0", play_bank);
    end
    clear_inject();
    pulse_load(7'd3, 7'd2);
    serve(1'b0, 1, 100);
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL zw_done_cnt: got %0d expected 1", done_cnt); end
    checks++;
    if (done_cyc[0] !== 17) begin errors++; $display("FAIL zw_latency: got %0d expected 17", done_cyc[0]); end
    checks++;
    if (pb_done[0] !== 1'b1) begin errors++; $display("FAIL zw_pb_at_done: got %b expected 1", pb_done[0]); end
    checks++;
    if (wr_cnt !== N) begin errors++; $display("FAIL zw_wr_cnt: got %0d expected %0d", wr_cnt, N); end
    checks++;
    if (req_log[0] !== 17'h00C10) begin errors++; $display("FAIL zw_first_addr: got %h expected 00c10", req_log[0]); end
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (wr_addr_log[i] !== ADDR_W'(i) || wr_data_log[i] !== exp_data(7'd3, 7'd2, ADDR_W'(i)) ||
          wr_bank_log[i] !== 1'b1 || req_log[i] !== exp_addr(7'd3, 7'd2, ADDR_W'(i))) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL zw_write_contents: got %0d bad writes expected 0", bad); end
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL zw_wr_req_overlap: got %0d expected 0", overlap); end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 0;
    @(negedge clk);
    checks++;
    if (play_bank !== 1'b1) begin errors++; $display("FAIL rm_pb_before: got %b expected 1", play_bank); end
    pulse_load(7'd2, 7'd6);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      wtb_load = 1'b0;
      src_ack  = 1'b0;
      if (src_req && src_addr[ADDR_W-1:0] == 3'd5) begin found = 1; break; end
      if (src_req) begin src_ack = 1'b1; src_data = src_addr[7:0] ^ 8'hA5; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rm_reach_idx5: got not reached expected reached"); end
    rst = 1'b1;
    #1;
    checks++;
    if ({src_req, src_addr, wr_en, wr_addr, wr_data, play_bank, busy, done} !== '0) begin
      errors++;
      $display("FAIL rm_async_outputs: got req=%b addr=%h wen=%b pb=%b busy=%b done=%b expected all 0",
               src_req, src_addr, wr_en, play_bank, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_inject();
    pulse_load(7'd3, 7'd2);
    serve(1'b0, 1, 100);
    checks++;
    if (wr_cnt !== N || done_cyc[0] !== 17 || pb_done[0] !== 1'b1) begin
      errors++;
      $display("FAIL rm_fresh_load: got wr=%0d cyc=%0d pb=%b expected 8 17 1", wr_cnt, done_cyc[0], pb_done[0]);
    end
  endtask

  task automatic test_random_latency();
    int bad, extra_done;
    clear_inject();
    pulse_load(7'd9, 7'd4);
    serve(1'b1, 1, 300);
    checks++;
    if (unstable !== 0) begin errors++; $display("FAIL rl_addr_stable: got %0d changes expected 0", unstable); end
    checks++;
    if (noack !== 0) begin errors++; $display("FAIL rl_write_no_ack: got %0d expected 0", noack); end
    checks++;
    if (wr_cnt !== N) begin errors++; $display("FAIL rl_wr_cnt: got %0d expected %0d", wr_cnt, N); end
    bad = 0;
    for (int i = 0; i < N; i++)
      if (wr_addr_log[i] !== ADDR_W'(i) || wr_data_log[i] !== exp_data(7'd9, 7'd4, ADDR_W'(i))) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rl_write_order: got %0d bad expected 0", bad); end
    extra_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    checks++;
    if (done_cnt !== 1 || extra_done !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rl_done_once: got done=%0d extra=%0d busy=%b expected 1 0 0", done_cnt, extra_done, busy);
    end
  endtask

  task automatic test_pending();
    logic p0;
    int bad;
    clear_inject();
    inj_cyc[0] = 3; inj_wtb[0] = 7'd1; inj_wfm[0] = 7'd1;
    inj_cyc[1] = 6; inj_wtb[1] = 7'd2; inj_wfm[1] = 7'd2;
    inj_cyc[2] = 9; inj_wtb[2] = 7'd4; inj_wfm[2] = 7'd4;
    @(negedge clk);
    p0 = play_bank;
    pulse_load(7'd5, 7'd5);
    serve(1'b0, 2, 200);
    clear_inject();
    checks++;
    if (done_cnt !== 2 || done_cyc[0] !== 17 || done_cyc[1] !== 34) begin
      errors++;
      $display("FAIL pd_done_timing: got cnt=%0d c0=%0d c1=%0d expected 2 17 34", done_cnt, done_cyc[0], done_cyc[1]);
    end
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (req_log[i] !== exp_addr(7'd5, 7'd5, ADDR_W'(i))) bad++;
      if (req_log[N+i] !== exp_addr(7'd4, 7'd4, ADDR_W'(i))) bad++;
    end
    checks++;
    if (bad !== 0 || req_cnt !== 2*N) begin
      errors++; $display("FAIL pd_latest_wins: got %0d bad reqs of %0d expected 0 of 16", bad, req_cnt);
    end
    checks++;
    if (busy_gap !== 0) begin errors++; $display("FAIL pd_busy_held: got %0d idle cycles expected 0", busy_gap); end
    checks++;
    if (pb_done[0] !== ~p0 || pb_done[1] !== p0) begin
      errors++; $display("FAIL pd_bank_toggles: got %b %b expected %b %b", pb_done[0], pb_done[1], ~p0, p0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || play_bank !== p0) begin
      errors++; $display("FAIL pd_no_third: got busy=%b pb=%b expected 0 %b", busy, play_bank, p0);
    end
  endtask

  task automatic test_done_restart();
    clear_inject();
    load_on_done = 1'b1; lod_wtb = 7'd7; lod_wfm = 7'd3;
    pulse_load(7'd6, 7'd1);
    serve(1'b0, 2, 200);
    clear_inject();
    checks++;
    if (done_cnt !== 2 || (done_cyc[1] - done_cyc[0]) !== 17 || busy_gap !== 0) begin
      errors++;
      $display("FAIL dr_restart: got cnt=%0d gap=%0d idle=%0d expected 2 17 0", done_cnt, done_cyc[1] - done_cyc[0], busy_gap);
    end
    checks++;
    if (req_log[N] !== exp_addr(7'd7, 7'd3, '0)) begin
      errors++; $display("FAIL dr_new_numbers: got %h expected %h", req_log[N], exp_addr(7'd7, 7'd3, '0));
    end
  endtask

  task automatic test_stray_ack();
    int bad;
    logic pb;
    bad = 0;
    repeat (2) @(negedge clk);
    pb = play_bank;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      src_ack  = 1'b1;
      src_data = 8'h5A;
      @(negedge clk);
      src_ack  = 1'b0;
      if (wr_en || busy || src_req || done) bad++;
    end
    checks++;
    if (bad !== 0 || play_bank !== pb) begin
      errors++; $display("FAIL stray_ack: got %0d bad cycles pb=%b expected 0 %b", bad, play_bank, pb);
    end
  endtask

  initial begin
    rst = 1'b0; wtb_load = 1'b0; wtb_num = '0; wfm_num = '0; src_ack = 1'b0; src_data = '0;
    clear_inject();
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_zero_wait();
    test_reset_mid();
    test_random_latency();
    test_pending();
    test_done_restart();
    test_stray_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
